// File: rtl/mod_subtractor_chk.sv
// mod_subtractor_chk
//   Limb-serial modular subtractor for the Curve448 field,
//   p = 2^448 - 2^224 - 1, computing oO = (iX - iY) mod p with a built-in
//   self-check that adds iY back onto the result mod p and compares it with iX.
//   Fixed 14-edge latency from the capture edge to ready, independent of data.
//
// Ports
//   clk     in   1    clock, rising edge
//   reset   in   1    synchronous, active-high
//   enable  in   1    start/hold; low returns the block to IDLE
//   iX      in   448  minuend   (expected < p)
//   iY      in   448  subtrahend (expected < p)
//   iFault  in   1    fault injection, sampled at capture (tie 0 in mission mode)
//   ready   out  1    result valid
//   oO      out  448  (iX - iY) mod p
//   err     out  1    self-check failure or operand out of range; valid with ready
module mod_subtractor_chk #(
  parameter int wI    = 448,
  parameter int NLIMB = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [wI-1:0] iX,
  input  logic [wI-1:0] iY,
  input  logic          iFault,
  output logic          ready,
  output logic [wI-1:0] oO,
  output logic          err
);

  localparam int wL = wI / NLIMB;

  // p = 2^448 - 2^224 - 1: all ones except bit 224 (bit 0 of limb 2)
  localparam logic [wI-1:0] P = {{(wI/2-1){1'b1}}, 1'b0, {(wI/2){1'b1}}};

  localparam logic [1:0] LAST = 2'd3;

  typedef enum logic [2:0] {IDLE, SUB, CORR, CHK, FIN, DONE} state_t;

  state_t state, state_next;

  logic [wI-1:0] xr, yr, d, s_lo;
  logic          fr, cb, bo, s_hi;
  logic [1:0]    k;

  logic [wL-1:0] p_limb;
  logic [wL:0]   diff, csum, ssum;
  logic [wI:0]   s_full, r_val;

  // ---------------------------------------------------------------------------
  // State register and next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (enable) state_next = SUB;
      SUB:  if (!enable) state_next = IDLE; else if (k == LAST) state_next = CORR;
      CORR: if (!enable) state_next = IDLE; else if (k == LAST) state_next = CHK;
      CHK:  if (!enable) state_next = IDLE; else if (k == LAST) state_next = FIN;
      FIN:  if (!enable) state_next = IDLE; else state_next = DONE;
      DONE: if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ready = (state == DONE);

  // ---------------------------------------------------------------------------
  // Limb arithmetic. Operand registers rotate right by one limb per step, so
  // the active limb is always at [wL-1:0]; four steps restore the original.
  // ---------------------------------------------------------------------------
  always_comb begin
    p_limb = (k == 2'd2) ? {{(wL-1){1'b1}}, 1'b0} : '1;
    diff   = {1'b0, xr[wL-1:0]} - {1'b0, yr[wL-1:0]} - {{wL{1'b0}}, cb};
    csum   = {1'b0, d[wL-1:0]} + (bo ? {1'b0, p_limb} : '0) + {{wL{1'b0}}, cb};
    ssum   = {1'b0, d[wL-1:0]} + {1'b0, yr[wL-1:0]} + {{wL{1'b0}}, cb};
    s_full = {s_hi, s_lo};
    r_val  = (s_full >= {1'b0, P}) ? s_full - {1'b0, P} : s_full;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xr   <= '0;
      yr   <= '0;
      fr   <= 1'b0;
      d    <= '0;
      s_lo <= '0;
      s_hi <= 1'b0;
      k    <= '0;
      cb   <= 1'b0;
      bo   <= 1'b0;
      oO   <= '0;
      err  <= 1'b0;
    end else if (!enable) begin
      k  <= '0;
      cb <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          xr <= iX;
          yr <= iY;
          fr <= iFault;
          k  <= '0;
          cb <= 1'b0;
        end
        SUB: begin
          d  <= {diff[wL-1:0], d[wI-1:wL]};
          xr <= {xr[wL-1:0], xr[wI-1:wL]};
          yr <= {yr[wL-1:0], yr[wI-1:wL]};
          k  <= k + 2'd1;
          if (k == LAST) begin
            bo <= diff[wL];
            cb <= 1'b0;
          end else begin
            cb <= diff[wL];
          end
        end
        CORR: begin
          k <= k + 2'd1;
          if (k == LAST) begin
            // Fault model applied on the way into CHK: flip bit 0 of D
            d  <= {csum[wL-1:0], d[wI-1:wL]} ^ {{(wI-1){1'b0}}, fr};
            cb <= 1'b0;
          end else begin
            d  <= {csum[wL-1:0], d[wI-1:wL]};
            cb <= csum[wL];
          end
        end
        CHK: begin
          s_lo <= {ssum[wL-1:0], s_lo[wI-1:wL]};
          d    <= {d[wL-1:0], d[wI-1:wL]};
          yr   <= {yr[wL-1:0], yr[wI-1:wL]};
          k    <= k + 2'd1;
          if (k == LAST) begin
            s_hi <= ssum[wL];
            cb   <= 1'b0;
          end else begin
            cb <= ssum[wL];
          end
        end
        FIN: begin
          oO  <= d;
          err <= (r_val != {1'b0, xr}) | (xr >= P) | (yr >= P);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_subtractor_chk.sv
module tb_mod_subtractor_chk;

  localparam logic [447:0] P_C = {{223{1'b1}}, 1'b0, {224{1'b1}}};

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [447:0] iX, iY;
  logic         iFault;
  logic         ready;
  logic [447:0] oO;
  logic         err;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [447:0] o;
    logic         e;
    bit           chk_o;
  } exp_t;

  exp_t sb[$];

  mod_subtractor_chk #(.wI(448), .NLIMB(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .iX(iX), .iY(iY),
    .iFault(iFault), .ready(ready), .oO(oO), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [447:0] obs, input logic [447:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [447:0] model(input logic [447:0] x, input logic [447:0] y);
    logic [449:0] t;
    if (x >= y) t = {2'b0, x} - {2'b0, y};
    else        t = {2'b0, x} + {2'b0, P_C} - {2'b0, y};
    return t[447:0];
  endfunction

  function automatic logic [447:0] rand_fe();
    logic [447:0] v;
    do begin
      for (int i = 0; i < 14; i++) v[i*32 +: 32] = $urandom;
    end while (v >= P_C);
    return v;
  endfunction

  // Full operation: capture edge is the first posedge after driving; ready
  // must be low after edge 13 and high after edge 14.
  task automatic run_op(input logic [447:0] x, input logic [447:0] y, input logic f,
                        input bit chk_o, input string tag);
    exp_t e;
    @(negedge clk);
    iX = x; iY = y; iFault = f; enable = 1'b1;
    e.o     = f ? (model(x, y) ^ 448'd1) : model(x, y);
    e.e     = f | (x >= P_C) | (y >= P_C);
    e.chk_o = chk_o;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    iX = ~x; iY = ~y; iFault = ~f;  // post-capture inputs must be ignored
    repeat (12) @(posedge clk);
    #1 check({tag, "_rdy13"}, {447'b0, ready}, 448'd0);
    @(posedge clk);
    #1 check({tag, "_rdy14"}, {447'b0, ready}, 448'd1);
    e = sb.pop_front();
    if (e.chk_o) check({tag, "_oO"}, oO, e.o);
    check({tag, "_err"}, {447'b0, err}, {447'b0, e.e});
    @(negedge clk);
    enable = 1'b0; iX = '0; iY = '0; iFault = 1'b0;
    @(posedge clk);
    #1 check({tag, "_rdyfall"}, {447'b0, ready}, 448'd0);
  endtask

  initial begin
    bit seen;
    reset = 1'b1; enable = 1'b0; iX = '0; iY = '0; iFault = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {447'b0, ready}, 448'd0);
    check("rst_oO", oO, 448'd0);
    check("rst_err", {447'b0, err}, 448'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(448'd10, 448'd3, 1'b0, 1'b1, "t1");
    run_op(448'd3, 448'd10, 1'b0, 1'b1, "t2");
    run_op(448'd0, P_C - 448'd1, 1'b0, 1'b1, "t3a");
    run_op(P_C - 448'd1, P_C - 448'd1, 1'b0, 1'b1, "t3b");
    run_op(448'd5, 448'd2, 1'b1, 1'b1, "t4");

    // T5a: enable dropped so edge 6 sees it low
    @(negedge clk);
    iX = 448'd500; iY = 448'd7; enable = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1 if (ready) seen = 1'b1;
    end
    check("t5_abort_noready", {447'b0, seen}, 448'd0);
    run_op(448'd100, 448'd1, 1'b0, 1'b1, "t5a");

    // T5b: reset pulse sampled at edge 9
    @(negedge clk);
    iX = 448'd500; iY = 448'd7; enable = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; enable = 1'b0;
    @(posedge clk);
    #1;
    check("t5_rst_ready", {447'b0, ready}, 448'd0);
    check("t5_rst_oO", oO, 448'd0);
    check("t5_rst_err", {447'b0, err}, 448'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(448'd100, 448'd1, 1'b0, 1'b1, "t5b");

    run_op(P_C, 448'd0, 1'b0, 1'b0, "t6");
    run_op(448'd0, P_C, 1'b0, 1'b0, "t6b");

    for (int n = 0; n < 1000; n++) begin
      run_op(rand_fe(), rand_fe(), 1'b0, 1'b1, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
